// File: rtl/rv32i_clint_bridge.sv
// Purpose : CLINT-style bus slave; turns 32-bit core writes into 64-bit mtime/mtimecmp commits, msip and a synced ext IRQ.
// Latency : every in-window strobe is acked exactly one cycle later; commit strobes fire together with that ack.
// Backpressure: none; one access is accepted per strobe cycle and there are no wait states.
// Ports   : bus slave (i_stb/i_wr_en/i_addr/i_wdata/i_wr_mask -> o_ack/o_rdata/o_err), live i_mtime in,
//           commit outputs o_mtime_wr/o_mtime_din and o_mtimecmp_wr/o_mtimecmp_din, o_sw_irq level,
//           i_ext_irq async pin in -> o_ext_irq synchronised level.
module rv32i_clint_bridge #(
   parameter logic [31:0] BASE_ADDR       = 32'h0200_0000,
   parameter logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter int          EXT_SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stb,
   input  logic        i_wr_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wr_mask,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic        o_err,
   input  logic [63:0] i_mtime,
   input  logic        i_ext_irq,
   output logic        o_mtime_wr,
   output logic [63:0] o_mtime_din,
   output logic        o_mtimecmp_wr,
   output logic [63:0] o_mtimecmp_din,
   output logic        o_sw_irq,
   output logic        o_ext_irq
);

   localparam logic [15:0] OFF_MSIP   = 16'h0000;
   localparam logic [15:0] OFF_CMP_LO = 16'h4000;
   localparam logic [15:0] OFF_CMP_HI = 16'h4004;
   localparam logic [15:0] OFF_MT_LO  = 16'hBFF8;
   localparam logic [15:0] OFF_MT_HI  = 16'hBFFC;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // cmp_shadow doubles as the mtimecmp commit value: both reset to MTIMECMP_RESET
   // and are loaded together on every mtimecmp commit.
   logic [63:0] cmp_shadow;
   logic [31:0] cmp_lo_stage, mt_lo_stage, rd_hi_snap;
   logic        cmp_lo_pend, mt_lo_pend, last_mt_lo_rd;
   logic [EXT_SYNC_STAGES-1:0] sync;

   logic [15:0] off;
   logic        hit, mapped, wr, rd;
   logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
   logic [63:0] cmp_commit, mt_commit;
   logic [31:0] rd_value;

   always_comb begin
      // Low address bits are don't-care: access is word addressed.
      off        = i_addr[15:0] & 16'hFFFC;
      hit        = i_stb && (i_addr[31:16] == BASE_ADDR[31:16]);
      sel_msip   = (off == OFF_MSIP);
      sel_cmp_lo = (off == OFF_CMP_LO);
      sel_cmp_hi = (off == OFF_CMP_HI);
      sel_mt_lo  = (off == OFF_MT_LO);
      sel_mt_hi  = (off == OFF_MT_HI);
      mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
      // An all-zero mask is acked but has no side effect at all (including no commit).
      wr         = hit && i_wr_en && (i_wr_mask != 4'b0000);
      rd         = hit && !i_wr_en;

      cmp_commit = {merge(cmp_shadow[63:32], i_wdata, i_wr_mask),
                    cmp_lo_pend ? cmp_lo_stage : cmp_shadow[31:0]};
      mt_commit  = {merge(i_mtime[63:32], i_wdata, i_wr_mask),
                    mt_lo_pend ? mt_lo_stage : i_mtime[31:0]};

      rd_value = 32'h0;
      if (sel_msip)   rd_value = {31'b0, o_sw_irq};
      if (sel_cmp_lo) rd_value = cmp_shadow[31:0];
      if (sel_cmp_hi) rd_value = cmp_shadow[63:32];
      if (sel_mt_lo)  rd_value = i_mtime[31:0];
      // A HI read straight after a LO read returns the high word captured with the LO,
      // so a carry between the two reads cannot tear the 64-bit value.
      if (sel_mt_hi)  rd_value = last_mt_lo_rd ? rd_hi_snap : i_mtime[63:32];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ack         <= 1'b0;
         o_err         <= 1'b0;
         o_rdata       <= 32'h0;
         o_mtime_wr    <= 1'b0;
         o_mtimecmp_wr <= 1'b0;
         o_mtime_din   <= 64'h0;
         o_sw_irq      <= 1'b0;
         cmp_shadow    <= MTIMECMP_RESET;
         cmp_lo_stage  <= 32'h0;
         mt_lo_stage   <= 32'h0;
         cmp_lo_pend   <= 1'b0;
         mt_lo_pend    <= 1'b0;
         rd_hi_snap    <= 32'h0;
         last_mt_lo_rd <= 1'b0;
         sync          <= '0;
      end else begin
         o_ack         <= hit;
         o_err         <= hit && !mapped;
         o_mtime_wr    <= wr && sel_mt_hi;
         o_mtimecmp_wr <= wr && sel_cmp_hi;
         sync          <= {sync[EXT_SYNC_STAGES-2:0], i_ext_irq};

         if (rd) o_rdata <= mapped ? rd_value : 32'h0;
         if (hit) last_mt_lo_rd <= rd && sel_mt_lo;
         if (rd && sel_mt_lo) rd_hi_snap <= i_mtime[63:32];

         if (wr && sel_msip && i_wr_mask[0]) o_sw_irq <= i_wdata[0];

         // LO writes always merge against the committed/live low word; the last one wins.
         if (wr && sel_cmp_lo) begin
            cmp_lo_stage <= merge(cmp_shadow[31:0], i_wdata, i_wr_mask);
            cmp_lo_pend  <= 1'b1;
         end
         if (wr && sel_cmp_hi) begin
            cmp_shadow  <= cmp_commit;
            cmp_lo_pend <= 1'b0;
         end
         if (wr && sel_mt_lo) begin
            mt_lo_stage <= merge(i_mtime[31:0], i_wdata, i_wr_mask);
            mt_lo_pend  <= 1'b1;
         end
         if (wr && sel_mt_hi) begin
            o_mtime_din <= mt_commit;
            mt_lo_pend  <= 1'b0;
         end
      end
   end

   assign o_mtimecmp_din = cmp_shadow;
   assign o_ext_irq      = sync[EXT_SYNC_STAGES-1];

endmodule

// File: tb/tb_rv32i_clint_bridge.sv
module tb_rv32i_clint_bridge;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_stb = 1'b0;
   logic        i_wr_en = 1'b0;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic [3:0]  i_wr_mask = 4'h0;
   logic [63:0] i_mtime = 64'h0;
   logic        i_ext_irq = 1'b0;
   logic        o_ack, o_err, o_mtime_wr, o_mtimecmp_wr, o_sw_irq, o_ext_irq;
   logic [31:0] o_rdata;
   logic [63:0] o_mtime_din, o_mtimecmp_din;

   rv32i_clint_bridge dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_stb(i_stb), .i_wr_en(i_wr_en), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_wr_mask(i_wr_mask), .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err),
      .i_mtime(i_mtime), .i_ext_irq(i_ext_irq), .o_mtime_wr(o_mtime_wr), .o_mtime_din(o_mtime_din),
      .o_mtimecmp_wr(o_mtimecmp_wr), .o_mtimecmp_din(o_mtimecmp_din), .o_sw_irq(o_sw_irq),
      .o_ext_irq(o_ext_irq));

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc = cyc + 1;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          due;
      bit          rd;
      logic [31:0] rdata;
      bit          err;
      bit          mtw;
      logic [63:0] mtd;
      bit          cmw;
      logic [63:0] cmd;
      bit          sw;
   } exp_t;
   exp_t q[$];

   // Reference model: architectural state of the CLINT window.
   bit          m_msip;
   logic [63:0] m_cmp;
   logic [31:0] m_cmp_lo, m_mt_lo, m_snap;
   bit          m_cmp_pend, m_mt_pend, m_prev_lo_rd;

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_msip = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_cmp_lo = 0; m_mt_lo = 0; m_snap = 0;
      m_cmp_pend = 0; m_mt_pend = 0; m_prev_lo_rd = 0;
   endtask

   // Issue one access in the current cycle (called #1 after a rising edge).
   task automatic acc(input bit wr, input logic [15:0] off, input logic [31:0] data,
                      input logic [3:0] mask, input bit inwin);
      exp_t e;
      i_stb = 1; i_wr_en = wr; i_wdata = data; i_wr_mask = mask;
      i_addr = inwin ? {16'h0200, off} : {16'h0300, off};
      if (inwin) begin
         e = '{due: cyc + 1, rd: !wr, rdata: 0, err: 0, mtw: 0, mtd: 0, cmw: 0, cmd: 0, sw: 0};
         if (!(off == 16'h0000 || off == 16'h4000 || off == 16'h4004 ||
               off == 16'hBFF8 || off == 16'hBFFC)) e.err = 1;
         if (!wr) begin
            case (off)
               16'h0000: e.rdata = {31'b0, m_msip};
               16'h4000: e.rdata = m_cmp[31:0];
               16'h4004: e.rdata = m_cmp[63:32];
               16'hBFF8: begin e.rdata = i_mtime[31:0]; m_snap = i_mtime[63:32]; end
               16'hBFFC: e.rdata = m_prev_lo_rd ? m_snap : i_mtime[63:32];
               default:  e.rdata = 0;
            endcase
         end else if (mask != 0) begin
            case (off)
               16'h0000: if (mask[0]) m_msip = data[0];
               16'h4000: begin m_cmp_lo = bmerge(m_cmp[31:0], data, mask); m_cmp_pend = 1; end
               16'h4004: begin
                  m_cmp = {bmerge(m_cmp[63:32], data, mask), m_cmp_pend ? m_cmp_lo : m_cmp[31:0]};
                  m_cmp_pend = 0; e.cmw = 1; e.cmd = m_cmp;
               end
               16'hBFF8: begin m_mt_lo = bmerge(i_mtime[31:0], data, mask); m_mt_pend = 1; end
               16'hBFFC: begin
                  e.mtd = {bmerge(i_mtime[63:32], data, mask), m_mt_pend ? m_mt_lo : i_mtime[31:0]};
                  m_mt_pend = 0; e.mtw = 1;
               end
               default: ;
            endcase
         end
         m_prev_lo_rd = !wr && off == 16'hBFF8;
         e.sw = m_msip;
         q.push_back(e);
      end
      @(posedge i_clk); #1;
      i_stb = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   // Monitor: response is due exactly one cycle after its strobe.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         while (q.size() > 0 && q[0].due < cyc) begin
            void'(q.pop_front());
            chk("missed_ack", 0, 1);
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("ack", o_ack, 1);
            chk("err", o_err, e.err);
            if (e.rd) chk("rdata", o_rdata, e.rdata);
            chk("mtime_wr", o_mtime_wr, e.mtw);
            if (e.mtw) chk("mtime_din", o_mtime_din, e.mtd);
            chk("mtimecmp_wr", o_mtimecmp_wr, e.cmw);
            if (e.cmw) chk("mtimecmp_din", o_mtimecmp_din, e.cmd);
            chk("sw_irq", o_sw_irq, e.sw);
         end else begin
            chk("idle_strobes", {o_ack, o_mtime_wr, o_mtimecmp_wr}, 3'b000);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [2:0] kind;
      logic [15:0] offs [7];
      offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234, 16'h0008};
      model_reset();
      idle(3);
      i_rst = 0;
      // Reset state
      chk("rst_ack", o_ack, 0);        chk("rst_err", o_err, 0);
      chk("rst_rdata", o_rdata, 0);    chk("rst_mtime_wr", o_mtime_wr, 0);
      chk("rst_cmp_wr", o_mtimecmp_wr, 0); chk("rst_mtime_din", o_mtime_din, 0);
      chk("rst_cmp_din", o_mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_sw", o_sw_irq, 0);      chk("rst_ext", o_ext_irq, 0);
      acc(0, 16'h4004, 0, 0, 1);

      // Staged LO then HI commit, read back
      acc(1, 16'h4000, 32'h0000_000F, 4'hF, 1);
      acc(1, 16'h4004, 32'h0, 4'hF, 1);
      acc(0, 16'h4000, 0, 0, 1);
      chk("cmp_model_t2", m_cmp, 64'h0000_0000_0000_000F);

      // HI write without pending LO uses live low word
      i_mtime = 64'h0000_0005_1234_5678;
      acc(1, 16'hBFFC, 32'h1, 4'hF, 1);

      // Carry between LO and HI read
      i_mtime = 64'h0000_0000_FFFF_FFFF;
      acc(0, 16'hBFF8, 0, 0, 1);
      i_mtime = 64'h0000_0001_0000_0000;
      acc(0, 16'hBFFC, 0, 0, 1);

      // MSIP masking
      acc(1, 16'h0000, 32'h1, 4'b0001, 1);
      acc(1, 16'h0000, 32'h0, 4'b0000, 1);
      acc(1, 16'h0000, 32'h0, 4'b0001, 1);

      // Unmapped in-window read, out-of-window strobe
      acc(0, 16'h1234, 0, 0, 1);
      acc(1, 16'h4004, 32'hDEAD_BEEF, 4'hF, 0);
      idle(2);

      // External IRQ sync: two edges
      i_ext_irq = 1;
      @(posedge i_clk); #1; chk("ext_after1", o_ext_irq, 0);
      @(posedge i_clk); #1; chk("ext_after2", o_ext_irq, 1);
      i_ext_irq = 0;
      idle(2);
      chk("ext_fall", o_ext_irq, 0);

      // Reset discards a staged LO
      acc(1, 16'h4000, 32'h1234_5678, 4'hF, 1);
      idle(2);
      i_rst = 1; model_reset();
      idle(1);
      i_rst = 0;
      chk("rst2_cmp_din", o_mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
      acc(1, 16'h4004, 32'h0000_000A, 4'hF, 1);
      chk("cmp_model_rst", m_cmp, 64'h0000_000A_FFFF_FFFF);

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0)
            i_mtime = {32'($urandom), 32'($urandom)};
         kind = 3'($urandom_range(0, 6));
         acc(1'($urandom_range(0, 1)), offs[kind], 32'($urandom),
             ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
             $urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) idle(1);
      end

      for (int w = 0; w < 20 && q.size() > 0; w++) idle(1);
      if (q.size() != 0) chk("drain", 64'(q.size()), 0);
      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
